// File: rtl/xc_sha256_msched_pkg.sv
// Shared definitions for the SHA-256 message-schedule engine and its sigma unit.
package xc_sha256_msched_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_OUT  = 2'd1,
      ST_SIG0 = 2'd2,
      ST_SIG1 = 2'd3
   } state_t;

   localparam logic [1:0] SS_SIGMA0 = 2'b00;
   localparam logic [1:0] SS_SIGMA1 = 2'b01;
   localparam logic [1:0] SS_SUM0   = 2'b10;
   localparam logic [1:0] SS_SUM1   = 2'b11;

   localparam int WORDS_IN  = 16;
   localparam int WORDS_OUT = 64;

   function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

endpackage

// File: rtl/xc_sha256_msched_if.sv
// Block-load and schedule-output handshake bundle of the message-schedule engine.
interface xc_sha256_msched_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [5:0]  out_idx;
   logic        out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );

endinterface

// File: rtl/xc_sha256.sv
// Lightweight SHA-256 sigma unit: small sigmas for the schedule, big sigmas for rounds.
module xc_sha256
   import xc_sha256_msched_pkg::*;
(
   input  logic [31:0] rs1,
   input  logic [1:0]  ss,
   output logic [31:0] result
);

   always_comb begin
      case (ss)
         SS_SIGMA0: result = ror32(rs1, 7)  ^ ror32(rs1, 18) ^ (rs1 >> 3);
         SS_SIGMA1: result = ror32(rs1, 17) ^ ror32(rs1, 19) ^ (rs1 >> 10);
         SS_SUM0:   result = ror32(rs1, 2)  ^ ror32(rs1, 13) ^ ror32(rs1, 22);
         default:   result = ror32(rs1, 6)  ^ ror32(rs1, 11) ^ ror32(rs1, 25);
      endcase
   end

endmodule

// File: rtl/xc_sha256_msched.sv
// SHA-256 message schedule: loads W0..W15, then streams W0..W63 using a 16-word
// circular buffer and one shared sigma unit (SIG0 accumulates, SIG1 writes back).
module xc_sha256_msched
   import xc_sha256_msched_pkg::*;
(
   input  logic             g_clk,
   input  logic             g_reset,
   xc_sha256_msched_if.slave bus
);

   state_t      state_q, state_d;
   logic [5:0]  t_q, t_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] msg_buf [WORDS_IN];

   logic        buf_we;
   logic [3:0]  buf_wa;
   logic [31:0] buf_wd;

   logic [1:0]  sig_ss;
   logic [31:0] sig_rs1;
   logic [31:0] sig_res;

   logic        in_ready, out_valid, in_hs, out_hs;
   logic [3:0]  idx_t, idx_t1, idx_t9, idx_t14;

   // Buffer slots relative to t: t-16 (= t mod 16), t-15, t-7, t-2.
   assign idx_t   = t_q[3:0];
   assign idx_t1  = idx_t + 4'd1;
   assign idx_t9  = idx_t + 4'd9;
   assign idx_t14 = idx_t + 4'd14;

   assign in_ready  = !g_reset && (state_q == ST_LOAD);
   assign out_valid = !g_reset && (state_q == ST_OUT);
   assign in_hs     = bus.in_valid && in_ready;
   assign out_hs    = out_valid && bus.out_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = msg_buf[idx_t];
   assign bus.out_idx   = g_reset ? 6'd0 : t_q;
   assign bus.out_last  = out_valid && (t_q == 6'(WORDS_OUT - 1));

   // Operand selection depends on state only, keeping the sigma path acyclic.
   assign sig_ss  = (state_q == ST_SIG1) ? SS_SIGMA1 : SS_SIGMA0;
   assign sig_rs1 = (state_q == ST_SIG1) ? msg_buf[idx_t14] : msg_buf[idx_t1];

   xc_sha256 u_sigma (
      .rs1    (sig_rs1),
      .ss     (sig_ss),
      .result (sig_res)
   );

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      acc_d   = acc_q;
      buf_we  = 1'b0;
      buf_wa  = idx_t;
      buf_wd  = bus.in_data;
      case (state_q)
         ST_LOAD: begin
            if (in_hs) begin
               buf_we = 1'b1;
               if (t_q == 6'(WORDS_IN - 1)) begin
                  t_d     = 6'd0;
                  state_d = ST_OUT;
               end else begin
                  t_d = t_q + 6'd1;
               end
            end
         end
         ST_OUT: begin
            if (out_hs) begin
               if (t_q == 6'(WORDS_OUT - 1)) begin
                  t_d     = 6'd0;
                  state_d = ST_LOAD;
               end else begin
                  t_d = t_q + 6'd1;
                  if (t_q >= 6'(WORDS_IN - 1)) state_d = ST_SIG0;
               end
            end
         end
         ST_SIG0: begin
            acc_d   = msg_buf[idx_t] + msg_buf[idx_t9] + sig_res;
            state_d = ST_SIG1;
         end
         ST_SIG1: begin
            buf_we  = 1'b1;
            buf_wd  = acc_q + sig_res;
            state_d = ST_OUT;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q <= ST_LOAD;
         t_q     <= 6'd0;
         acc_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         acc_q   <= acc_d;
      end
   end

   // W[t] overwrites W[t-16], which no later schedule word needs.
   always_ff @(posedge g_clk) begin
      if (buf_we) msg_buf[buf_wa] <= buf_wd;
   end

endmodule

// File: tb/tb_xc_sha256_msched.sv
// Directed and table-driven bench for the SHA-256 message-schedule engine.
module tb_xc_sha256_msched;

   logic g_clk;
   logic g_reset;
   xc_sha256_msched_if bus ();

   xc_sha256_msched dut (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .bus     (bus)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge g_clk) cyc <= cyc + 1;

   logic [31:0] blk  [16];
   logic [31:0] gold [64];
   logic [31:0] rblk [3][16];

   logic [31:0] cap_data [64];
   logic [5:0]  cap_idx  [64];
   logic        cap_last [64];
   int          cap_cyc  [64];
   int          cap_n = 0;
   int          in_first_cyc, in_last_cyc;

   typedef struct {
      logic [31:0] w0;
      logic [31:0] w15;
      int          idx;
      logic [31:0] exp_w;
   } vec_t;
   vec_t vt [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic build_golden();
      for (int i = 0; i < 64; i++) begin
         if (i < 16) gold[i] = blk[i];
         else gold[i] = (rotr(gold[i-2], 17) ^ rotr(gold[i-2], 19) ^ (gold[i-2] >> 10))
                      + gold[i-7]
                      + (rotr(gold[i-15], 7) ^ rotr(gold[i-15], 18) ^ (gold[i-15] >> 3))
                      + gold[i-16];
      end
   endtask

   // Output monitor: captures handshakes and checks hold/exclusivity rules.
   logic        hold_q = 1'b0;
   logic [31:0] hold_data;
   logic [5:0]  hold_idx;
   logic        hold_last;
   always @(negedge g_clk) begin
      if (!g_reset) begin
         if (bus.out_valid) check("in_ready_during_out", bus.in_ready, 1'b0);
         if (hold_q) begin
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_data", bus.out_data, hold_data);
            check("hold_idx", bus.out_idx, hold_idx);
            check("hold_last", bus.out_last, hold_last);
         end
         hold_q    = bus.out_valid && !bus.out_ready;
         hold_data = bus.out_data;
         hold_idx  = bus.out_idx;
         hold_last = bus.out_last;
         if (bus.out_valid && bus.out_ready && cap_n < 64) begin
            cap_data[cap_n] = bus.out_data;
            cap_idx[cap_n]  = bus.out_idx;
            cap_last[cap_n] = bus.out_last;
            cap_cyc[cap_n]  = cyc;
            cap_n++;
         end
      end else begin
         hold_q = 1'b0;
      end
   end

   task automatic cap_clear();
      for (int i = 0; i < 64; i++) begin
         cap_data[i] = 'x;
         cap_idx[i]  = 'x;
         cap_last[i] = 1'bx;
      end
      cap_n = 0;
   endtask

   task automatic load_word(input logic [31:0] w, input bit rnd, output int hs_cyc);
      int  guard = 0;
      bit  done  = 0;
      hs_cyc = -1;
      while (!done) begin
         bus.in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.in_data  = bus.in_valid ? w : $urandom;
         @(negedge g_clk);
         if (bus.in_valid && bus.in_ready) begin
            done   = 1;
            hs_cyc = cyc;
         end
         @(posedge g_clk);
         #1;
         guard++;
         if (!done && guard > 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL load_timeout: in_ready never accepted word 0x%08h", w);
            done = 1;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic load_block(input bit rnd);
      int hc;
      for (int i = 0; i < 16; i++) begin
         load_word(blk[i], rnd, hc);
         if (i == 0)  in_first_cyc = hc;
         if (i == 15) in_last_cyc  = hc;
      end
   endtask

   task automatic drain(input bit rnd, input int target, input bit offer, input logic [31:0] next_w0);
      int guard = 0;
      if (offer) begin
         bus.in_valid = 1'b1;
         bus.in_data  = next_w0;
      end
      while (cap_n < target && guard < 3000) begin
         bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(posedge g_clk);
         #1;
         guard++;
      end
      bus.out_ready = 1'b0;
      if (cap_n < target) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: got %0d words required %0d", cap_n, target);
      end
   endtask

   task automatic compare_all(input string tag);
      build_golden();
      check({tag, "_count"}, cap_n, 64);
      for (int i = 0; i < 64; i++) begin
         check($sformatf("%s_w%0d", tag, i), cap_data[i], gold[i]);
         check($sformatf("%s_idx%0d", tag, i), cap_idx[i], 32'(i));
         check($sformatf("%s_last%0d", tag, i), cap_last[i], (i == 63));
      end
   endtask

   task automatic pulse_reset(input string tag);
      g_reset = 1'b1;
      @(negedge g_clk);
      check({tag, "_rst_in_ready"}, bus.in_ready, 1'b0);
      check({tag, "_rst_out_valid"}, bus.out_valid, 1'b0);
      check({tag, "_rst_out_idx"}, bus.out_idx, 6'd0);
      check({tag, "_rst_out_last"}, bus.out_last, 1'b0);
      @(posedge g_clk);
      #1;
      g_reset = 1'b0;
      @(negedge g_clk);
      check({tag, "_post_in_ready"}, bus.in_ready, 1'b1);
      check({tag, "_post_out_valid"}, bus.out_valid, 1'b0);
      @(posedge g_clk);
      #1;
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad_gap;
      vt[0] = '{32'h61626380, 32'h00000018, 0,  32'h61626380};
      vt[1] = '{32'h61626380, 32'h00000018, 15, 32'h00000018};
      vt[2] = '{32'h61626380, 32'h00000018, 16, 32'h61626380};
      vt[3] = '{32'h61626380, 32'h00000018, 17, 32'h000F0000};
      vt[4] = '{32'h00000000, 32'h80000000, 16, 32'h00000000};
      vt[5] = '{32'h00000000, 32'h80000000, 17, 32'h00205000};
      vt[6] = '{32'h00000000, 32'h00000000, 63, 32'h00000000};
      vt[7] = '{32'h00000000, 32'h00000000, 32, 32'h00000000};

      bus.in_valid  = 1'b0;
      bus.in_data   = 32'h0;
      bus.out_ready = 1'b0;
      g_reset       = 1'b1;
      repeat (3) @(posedge g_clk);
      #1;
      pulse_reset("init");

      // Table: each record loads a block at full rate and spot-checks one word.
      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < 16; i++) blk[i] = 32'h0;
         blk[0]  = vt[v].w0;
         blk[15] = vt[v].w15;
         cap_clear();
         load_block(1'b0);
         drain(1'b0, 64, 1'b0, 32'h0);
         compare_all($sformatf("vec%0d", v));
         check($sformatf("vec%0d_spot_w%0d", v, vt[v].idx), cap_data[vt[v].idx], vt[v].exp_w);
         check($sformatf("vec%0d_first_out_lat", v), cap_cyc[0] - in_last_cyc, 1);
         check($sformatf("vec%0d_block_cycles", v), cap_cyc[63] - in_first_cyc + 1, 176);
         bad_gap = 0;
         for (int i = 0; i < 63; i++)
            if (cap_cyc[i+1] - cap_cyc[i] != ((i < 15) ? 1 : 3)) bad_gap++;
         check($sformatf("vec%0d_out_spacing", v), bad_gap, 0);
      end

      // Three back-to-back random blocks with random valid/ready.
      for (int b = 0; b < 3; b++)
         for (int i = 0; i < 16; i++) rblk[b][i] = $urandom;
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 16; i++) blk[i] = rblk[b][i];
         cap_clear();
         load_block(1'b1);
         drain(1'b1, 64, (b < 2), (b < 2) ? rblk[(b + 1) % 3][0] : 32'h0);
         compare_all($sformatf("rnd%0d", b));
      end
      bus.in_valid = 1'b0;
      @(posedge g_clk);
      #1;

      // Reset while computing W30 (engine sits in SIG0 with t=30).
      set_abc();
      cap_clear();
      load_block(1'b0);
      drain(1'b0, 30, 1'b0, 32'h0);
      @(negedge g_clk);
      check("mid30_out_valid", bus.out_valid, 1'b0);
      check("mid30_out_idx", bus.out_idx, 6'd30);
      @(posedge g_clk);
      #1;
      pulse_reset("mid30");
      cap_clear();
      load_block(1'b0);
      drain(1'b0, 64, 1'b0, 32'h0);
      compare_all("after30");
      check("after30_w16", cap_data[16], 32'h61626380);
      check("after30_w17", cap_data[17], 32'h000F0000);
      check("after30_block_cycles", cap_cyc[63] - in_first_cyc + 1, 176);

      // Reset after a partial load of 7 words.
      cap_clear();
      for (int i = 0; i < 7; i++) begin
         int hc;
         load_word(32'hA5A50000 | 32'(i), 1'b0, hc);
      end
      pulse_reset("part7");
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      cap_clear();
      load_block(1'b1);
      drain(1'b1, 64, 1'b0, 32'h0);
      compare_all("part7");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/xc_sha256_msched.md
# xc_sha256_msched

Sequential SHA-256 message-schedule engine. It accepts one 512-bit message block as 16 big-endian 32-bit words W0..W15 and streams out the full schedule W0..W63 in order. It is built around the lightweight SHA-256 sigma function unit, instantiated as the datapath, and sits between the block-load path and a round engine that consumes one Wt per round.

## Interface
- Parameters: none.
- g_clk     in   1   clock; all state updates on the rising edge
- g_reset   in   1   synchronous, active-high reset
- in_valid  in   1   in_data holds a valid message word
- in_ready  out  1   block can accept a word this cycle
- in_data   in   32  message word, W0 first
- out_valid out  1   out_data/out_idx hold schedule word Wt
- out_ready in   1   consumer takes Wt this cycle
- out_data  out  32  Wt
- out_idx   out  6   t, 0..63
- out_last  out  1   high with out_valid when t == 63

## Operation
- Storage: 16 x 32-bit circular buffer `buf`, indexed mod 16; 6-bit counter `t`; 32-bit accumulator `acc`; FSM.
- States:
  - LOAD: in_ready=1. Each in_valid&in_ready writes buf[t[3:0]] and increments t. On the 16th accept, t←0 and the FSM goes to OUT.
  - OUT: out_valid=1, out_data=buf[t[3:0]], out_idx=t. On out_ready:
    - t==63 → t←0, go to LOAD.
    - else t←t+1; the next t ≥16 → SIG0; else stay in OUT.
  - SIG0: sigma unit ss=00 on buf[(t+1)&15], i.e. σ0(W[t-15]). acc←buf[t&15] (W[t-16]) + buf[(t+9)&15] (W[t-7]) + σ0.
  - SIG1: sigma unit ss=01 on buf[(t+14)&15], i.e. σ1(W[t-2]). buf[t&15]←acc+σ1, overwriting W[t-16], which is no longer needed. Go to OUT.
- Arithmetic: all additions are mod 2^32; carries are discarded.
- One sigma unit is shared by SIG0 and SIG1. ss is driven from state and is 00 or 01 only; 10/11 are never used.
- in_ready=0 outside LOAD. Input words offered during OUT/SIG0/SIG1 are held off, never dropped.
- Output words are never skipped or duplicated.

## Timing
- Reset: while g_reset=1, in_ready=0, out_valid=0, out_last=0, out_idx=0 (all gated). The edge with g_reset=1 forces state LOAD, t=0, acc=0. buf is not reset and its contents are don't-care.
- Reset mid-operation (any state, any t): the next cycle is LOAD with t=0. The partial block is discarded, and the next accepted word is W0.
- Load→first output: out_valid rises the cycle after the 16th input handshake.
- Throughput:
  - W0..W15: one word per cycle when out_ready is held high.
  - W16..W63: 3 cycles per word (SIG0, SIG1, OUT).
  - A full block takes 16 + 16 + 48×3 = 176 cycles minimum.
- Back-pressure: while out_valid & !out_ready, out_data, out_idx and out_last stay stable and the FSM holds.
- Turnaround: the W63 handshake makes in_ready=1 on the next cycle. No bubble beyond that.
- out_valid never depends combinationally on out_ready. in_ready never depends on in_valid.

## Structure
- Sub-module: `xc_sha256`, one instance, is the sigma datapath (rs1, ss → result).
- Shared package holds:
  - FSM state encoding (LOAD, OUT, SIG0, SIG1)
  - constants SS_SIGMA0=2'b00, SS_SIGMA1=2'b01
  - constants WORDS_IN=16, WORDS_OUT=64
- Everything else is local. Target size is about 150–200 lines.

## Test plan
- "abc" padded block, W0=0x61626380, W1..W14=0, W15=0x00000018, out_ready=1 → W16=0x61626380 and W17=0x000F0000. All 64 words match a golden FIPS 180-4 model, and out_last is high only at out_idx=63.
- W15=0x80000000, all others 0 → W16=0x00000000 and W17=0x00205000. Checks σ1 rotate/shift combined with mod-2^32 sums.
- All-zero block → all 64 out_data=0. out_valid pattern is 16 consecutive cycles, then one valid every 3rd cycle. Total 176 cycles from the first input to the W63 handshake.
- Random out_ready/in_valid toggling over 3 back-to-back random blocks → output matches the golden model word for word. out_data is stable whenever out_valid & !out_ready. in_ready=0 during output.
- g_reset pulsed for one cycle at t=30 (state SIG0) → next cycle out_valid=0 and in_ready=1. A fresh "abc" block then reproduces the first scenario exactly.
- g_reset pulsed after only 7 input words → the following 16 words form W0..W15 of a clean block, and the output matches the golden model.
